// File: rtl/ikbd_pkg.sv
// Shared types and helpers for the key-matrix scanner.
package ikbd_pkg;

    // Widest row count and scancode supported (32 columns x 16 rows = 512 keys).
    localparam int MAX_ROWS   = 16;
    localparam int MAX_CODE_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        EMIT   = 2'd3
    } scan_state_t;

    // One make/break event; the code field is sized for the largest matrix,
    // and narrower matrices use only its low bits.
    typedef struct packed {
        logic                  brk;
        logic [MAX_CODE_W-1:0] code;
    } ikbd_evt_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] lowest_set(input logic [MAX_ROWS-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = MAX_ROWS - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ikbd_evt_fifo.sv
// Synchronous event FIFO with a registered head, so the outputs stay steady
// while the consumer holds off.
module ikbd_evt_fifo
    import ikbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          res,
    input  logic          push_i,
    input  ikbd_evt_t     din_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o,
    output ikbd_evt_t     head_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    ikbd_evt_t     head_q, head_d;
    ikbd_evt_t     mem_q [FIFO_DEPTH];
    logic          do_push, do_pop;

    assign full_o  = (level_q == LW'(FIFO_DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = head_q;

    // Pop frees a slot before the push is judged; the next head is taken from
    // the entry that becomes oldest, bypassing storage when it arrives now.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LW'(1);
        end
        head_d = '0;
        if (level_d != '0) begin
            head_d = (do_push && (wr_q == rd_d)) ? din_i : mem_q[rd_d];
        end
    end

    // Pointer, level and head registers.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            head_q  <= head_d;
        end
    end

    // Event storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/ikbd_matrix_scan.sv
// Key-matrix scanner: one-cold column drive, per-key debounce over scan
// passes, and make/break events serialised into a FIFO.
module ikbd_matrix_scan
    import ikbd_pkg::*;
#(
    parameter int COLS       = 15,
    parameter int ROWS       = 8,
    parameter int SCAN_DIV   = 64,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int CW        = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            res,
    input  logic            en,
    output logic [COLS-1:0] col_n,
    input  logic [ROWS-1:0] row_n,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [CW-1:0]   ev_code,
    output logic            ev_break,
    output logic [LW-1:0]   fifo_level,
    output logic            any_down
);

    localparam int KEYS = COLS * ROWS;
    localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DIVW = $clog2(SCAN_DIV);
    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE);

    scan_state_t     state_q, state_d;
    logic [COLW-1:0] col_q, col_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [ROWS-1:0] mask_q, mask_d;
    logic [KEYS-1:0] stable_q, stable_d;
    logic [3:0]      cnt_q [KEYS];
    logic [3:0]      cnt_d [KEYS];
    logic            any_down_q;
    logic [COLS-1:0] col_n_q;

    logic [MAX_ROWS-1:0] mask_ext;
    logic [3:0]          sel_row;
    logic [CW-1:0]       emit_key;
    logic [CW-1:0]       samp_key;
    logic                advance;
    logic                push;
    logic                can_push;
    ikbd_evt_t           evt;
    ikbd_evt_t           head;
    logic                fifo_full;
    logic                fifo_empty;

    assign ev_valid = !fifo_empty;
    assign ev_code  = head.code[CW-1:0];
    assign ev_break = head.brk;
    assign any_down = any_down_q;
    assign col_n    = col_n_q;
    // A full FIFO still accepts when the consumer takes the head this cycle.
    assign can_push = !fifo_full || (ev_ready && ev_valid);

    // Next-state logic: column timing, row sampling with debounce, and
    // draining the pending mask into the FIFO lowest row first.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        div_d    = div_q;
        mask_d   = mask_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        advance  = 1'b0;
        push     = 1'b0;
        evt      = '0;
        samp_key = '0;
        mask_ext = '0;
        mask_ext[ROWS-1:0] = mask_q;
        sel_row  = lowest_set(mask_ext);
        emit_key = CW'(col_q) * CW'(ROWS) + CW'(sel_row);

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SETTLE;
                    div_d   = '0;
                end
            end
            SETTLE: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (div_q == DIVW'(SCAN_DIV - 1)) begin
                    state_d = SAMPLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            SAMPLE: begin
                for (int r = 0; r < ROWS; r++) begin
                    samp_key = CW'(col_q) * CW'(ROWS) + CW'(r);
                    if (!row_n[r] == stable_q[samp_key]) begin
                        cnt_d[samp_key] = '0;
                    end else begin
                        if (cnt_q[samp_key] != CNT_MAX) begin
                            cnt_d[samp_key] = cnt_q[samp_key] + 4'd1;
                        end
                        if (cnt_d[samp_key] == CNT_MAX) begin
                            mask_d[r] = 1'b1;
                        end
                    end
                end
                if (mask_d == '0) begin
                    advance = 1'b1;
                end else begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (can_push) begin
                    push               = 1'b1;
                    evt.brk            = stable_q[emit_key];
                    evt.code           = MAX_CODE_W'(emit_key);
                    stable_d[emit_key] = !stable_q[emit_key];
                    cnt_d[emit_key]    = '0;
                    mask_d             = mask_q & ~(ROWS'(1) << sel_row);
                    if (mask_d == '0) begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = SETTLE;
        endcase

        if (advance) begin
            col_d   = (col_q == COLW'(COLS - 1)) ? '0 : col_q + COLW'(1);
            div_d   = '0;
            state_d = en ? SETTLE : IDLE;
        end
    end

    // State, counters, debounce arrays and registered outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= SETTLE;
            col_q      <= '0;
            div_q      <= '0;
            mask_q     <= '0;
            stable_q   <= '0;
            any_down_q <= 1'b0;
            col_n_q    <= '1;
            for (int i = 0; i < KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            div_q      <= div_d;
            mask_q     <= mask_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            any_down_q <= |stable_q;
            col_n_q    <= ((state_q != IDLE) && en) ? ~(COLS'(1) << col_q) : '1;
        end
    end

    ikbd_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LW         (LW)
    ) u_fifo (
        .clk     (clk),
        .res     (res),
        .push_i  (push),
        .din_i   (evt),
        .pop_i   (ev_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level),
        .head_o  (head)
    );

endmodule

// File: tb/tb_ikbd_matrix_scan.sv
// Bench for ikbd_matrix_scan: a 4x4 matrix model drives the rows from the
// column selects; a behavioural scanner model predicts every output cycle.
module tb_ikbd_matrix_scan;

    localparam int COLS = 4, ROWS = 4, SCAN_DIV = 4, DEBOUNCE = 3, DEPTH = 4;
    localparam int M_IDLE = 0, M_SETTLE = 1, M_SAMPLE = 2, M_EMIT = 3;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       en = 1'b1;
    logic       ev_ready = 1'b1;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic       ev_valid;
    logic [3:0] ev_code;
    logic       ev_break;
    logic [2:0] fifo_level;
    logic       any_down;

    always #5 clk = ~clk;

    ikbd_matrix_scan #(
        .COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .res(res), .en(en), .col_n(col_n), .row_n(row_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_break(ev_break), .fifo_level(fifo_level), .any_down(any_down)
    );

    // Physical key matrix: a closed key pulls its row low while its column is driven.
    logic [3:0] keys [COLS];
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (!col_n[c] && keys[c][r]) row_n[r] = 1'b0;
    end

    int n_cmp = 0, n_err = 0, cyc = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model of the scanner.
    int  m_phase, m_col, m_div;
    bit  m_stable [COLS][ROWS];
    int  m_cnt [COLS][ROWS];
    int  pend[$];
    int  fq_code[$];
    bit  fq_brk[$];
    logic [3:0] e_col_n;
    bit  e_any;

    task automatic m_next_col();
        m_col   = (m_col + 1) % COLS;
        m_div   = 0;
        m_phase = en ? M_SETTLE : M_IDLE;
    endtask

    always @(posedge clk) begin
        bit any_now;
        int r;
        if (res) begin
            m_phase = M_SETTLE; m_col = 0; m_div = 0;
            foreach (m_stable[c, rr]) begin m_stable[c][rr] = 0; m_cnt[c][rr] = 0; end
            pend.delete(); fq_code.delete(); fq_brk.delete();
            e_col_n = 4'hF; e_any = 0;
        end else begin
            any_now = 0;
            foreach (m_stable[c, rr]) any_now |= m_stable[c][rr];
            e_any   = any_now;
            e_col_n = (m_phase != M_IDLE && en) ? ~(4'b1 << m_col) : 4'hF;
            if (ev_ready && fq_code.size() > 0) begin
                void'(fq_code.pop_front());
                void'(fq_brk.pop_front());
            end
            case (m_phase)
                M_IDLE: if (en) begin m_phase = M_SETTLE; m_div = 0; end
                M_SETTLE: begin
                    if (!en) m_phase = M_IDLE;
                    else if (m_div == SCAN_DIV - 1) m_phase = M_SAMPLE;
                    else m_div++;
                end
                M_SAMPLE: begin
                    for (int rr = 0; rr < ROWS; rr++) begin
                        if (keys[m_col][rr] == m_stable[m_col][rr]) m_cnt[m_col][rr] = 0;
                        else begin
                            if (m_cnt[m_col][rr] < DEBOUNCE) m_cnt[m_col][rr]++;
                            if (m_cnt[m_col][rr] == DEBOUNCE) pend.push_back(rr);
                        end
                    end
                    if (pend.size() == 0) m_next_col();
                    else m_phase = M_EMIT;
                end
                default: begin
                    if (fq_code.size() < DEPTH) begin
                        r = pend.pop_front();
                        fq_code.push_back(m_col * ROWS + r);
                        fq_brk.push_back(m_stable[m_col][r]);
                        m_stable[m_col][r] = !m_stable[m_col][r];
                        m_cnt[m_col][r] = 0;
                        if (pend.size() == 0) m_next_col();
                    end
                end
            endcase
        end
    end

    // Accepted events as seen by the consumer.
    int got_code[$];
    int got_brk[$];
    int got_cyc[$];
    always @(posedge clk) begin
        cyc++;
        if (!res && ev_valid && ev_ready) begin
            got_code.push_back(ev_code);
            got_brk.push_back(ev_break);
            got_cyc.push_back(cyc);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("col_n", col_n, e_col_n);
            check("any_down", any_down, e_any);
            check("ev_valid", ev_valid, fq_code.size() != 0);
            check("fifo_level", fifo_level, fq_code.size());
            if (fq_code.size() != 0) begin
                check("ev_code", ev_code, fq_code[0]);
                check("ev_break", ev_break, fq_brk[0]);
            end
        end
    end

    task automatic wait_phase(input int ph, input int col, input string nm);
        int n;
        bit hit;
        n = 0; hit = 0;
        while (!hit && n < 500) begin
            @(negedge clk);
            n++;
            hit = (m_phase == ph) && (m_col == col);
        end
        check(nm, hit, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base;

    initial begin
        for (int c = 0; c < COLS; c++) keys[c] = 4'h0;
        idle(3);
        // Leaving reset: columns stay released one more cycle.
        res = 1'b0;
        check("rst_col_n", col_n, 4'hF);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_any_down", any_down, 0);
        check("rst_code", ev_code, 0);
        check("rst_break", ev_break, 0);
        chk_en = 1;
        idle(1);
        check("rst_first_col", col_n, 4'hE);

        // Single key press and release: col2/row1 -> code 9.
        base = got_code.size();
        keys[2][1] = 1'b1;
        idle(100);
        check("press_count", got_code.size() - base, 1);
        check("press_code", got_code[base], 9);
        check("press_brk", got_brk[base], 0);
        check("press_any_down", any_down, 1);
        keys[2][1] = 1'b0;
        idle(100);
        check("release_count", got_code.size() - base, 2);
        check("release_code", got_code[base+1], 9);
        check("release_brk", got_brk[base+1], 1);
        check("release_any_down", any_down, 0);

        // Bounce on col0/row2: closed, closed, open, closed, closed, open.
        base = got_code.size();
        for (int p = 1; p <= 6; p++) begin
            wait_phase(M_SAMPLE, 0, "bounce_sample_reached");
            keys[0][2] = (p % 3 != 0);
        end
        idle(60);
        check("bounce_no_event", got_code.size() - base, 0);

        // Two rows of col1 closing together.
        base = got_code.size();
        keys[1] = 4'b1001;
        idle(100);
        check("simul_count", got_code.size() - base, 2);
        check("simul_code0", got_code[base], 4);
        check("simul_code1", got_code[base+1], 7);
        check("simul_back_to_back", got_cyc[base+1] - got_cyc[base], 1);
        keys[1] = 4'b0000;
        idle(100);

        // Backpressure: six keys, consumer stalled, pressed just after col3 sample.
        ev_ready = 1'b0;
        wait_phase(M_SAMPLE, 3, "bp_align_reached");
        idle(1);
        keys[0] = 4'b0011;
        keys[2] = 4'b1101;
        keys[3] = 4'b1000;
        idle(100);
        check("bp_level_full", fifo_level, 4);
        check("bp_col_frozen", col_n, 4'hB);
        idle(20);
        check("bp_col_still", col_n, 4'hB);
        check("bp_level_still", fifo_level, 4);
        base = got_code.size();
        ev_ready = 1'b1;
        idle(100);
        check("bp_count", got_code.size() - base, 6);
        check("bp_code0", got_code[base], 0);
        check("bp_code1", got_code[base+1], 1);
        check("bp_code2", got_code[base+2], 8);
        check("bp_code3", got_code[base+3], 10);
        check("bp_code4", got_code[base+4], 11);
        check("bp_code5", got_code[base+5], 15);
        keys[0] = 4'h0; keys[2] = 4'h0; keys[3] = 4'h0;
        idle(150);

        // Enable dropped on the first EMIT cycle of col1.
        base = got_code.size();
        keys[1] = 4'b0111;
        wait_phase(M_EMIT, 1, "en_emit_reached");
        en = 1'b0;
        idle(10);
        check("en_off_cols", col_n, 4'hF);
        check("en_drain_count", got_code.size() - base, 3);
        check("en_drain_code0", got_code[base], 4);
        check("en_drain_code1", got_code[base+1], 5);
        check("en_drain_code2", got_code[base+2], 6);
        en = 1'b1;
        idle(1);
        check("en_resume_lag", col_n, 4'hF);
        idle(1);
        check("en_resume_next_col", col_n, 4'hB);
        keys[1] = 4'h0;
        idle(150);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
